lfsr_encrypt_engine: RTL

//  Hardware encryptor: counterpart of the decrypt program run on top. Reads a

---
 rtl/crypt_pkg.sv | 22 ++
 rtl/lfsr8_step.sv | 13 +
 rtl/lfsr_encrypt_engine.sv | 138 +++++++++++++
 3 files changed

// File: rtl/crypt_pkg.sv
// Shared types and constants for the LFSR frame encryptor and its decrypt counterpart.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package crypt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_PAD   = 3'd2,
        ST_RD    = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5
    } enc_state_t;

    // Pad character placed around the message inside the frame.
    localparam logic [7:0] SPACE = 8'h20;

    // Known-good feedback tap masks, shared with the decrypt side.
    localparam logic [7:0] LFSR_PTRN [8] = '{8'hE1, 8'hD4, 8'hC6, 8'hB8,
                                             8'hB4, 8'hB2, 8'hFA, 8'hF3};

endpackage

// File: rtl/lfsr8_step.sv
// One step of the 8-bit shift-left LFSR: nxt = {state[6:0], parity(state & taps)}.
// Latency: combinational.
// Backpressure: none.
// Ports: state (current value), taps (feedback mask), nxt (next value).
module lfsr8_step (
    input  logic [7:0] state,
    input  logic [7:0] taps,
    output logic [7:0] nxt
);

    assign nxt = {state[6:0], ^(state & taps)};

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// Builds a space-padded frame around a plaintext message in memory, XORs it with an LFSR stream and writes it back.
// Latency: start to done = 2 + pad bytes + 2 * message bytes (one cycle per pad byte, read+write per message byte).
// Backpressure: none; single RW memory port, start ignored while busy.
// Ports: clk/reset (async active-low); start/taps/seed/pre_len config; mem_* memory port;
//        busy while the frame is produced, done level when finished, err with done on bad config.
module lfsr_encrypt_engine
    import crypt_pkg::*;
#(
    parameter int MSG_LEN   = 55,
    parameter int FRAME_LEN = 64,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] taps,
    input  logic [7:0] seed,
    input  logic [5:0] pre_len,
    output logic [7:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       err
);

    enc_state_t state;
    logic [6:0] idx;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic [7:0] taps_q;
    logic [7:0] seed_q;
    logic [5:0] pre_q;
    logic       err_q;

    logic [6:0] idx_nxt;
    logic       last;
    enc_state_t after_wr;

    lfsr8_step u_step (
        .state (lfsr),
        .taps  (taps_q),
        .nxt   (lfsr_nxt)
    );

    // Frame position i carries a message byte when 0 <= i - pre_len < MSG_LEN.
    // The difference fits in 7-bit two's complement since both operands are below 64.
    function automatic logic in_msg(input logic [6:0] i, input logic [5:0] pl);
        logic [6:0] d;
        d = i - {1'b0, pl};
        return !d[6] && (d < 7'(MSG_LEN));
    endfunction

    assign idx_nxt  = idx + 7'd1;
    assign last     = (idx == 7'(FRAME_LEN - 1));
    assign after_wr = last ? ST_DONE : (in_msg(idx_nxt, pre_q) ? ST_RD : ST_PAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            lfsr   <= '0;
            taps_q <= '0;
            seed_q <= '0;
            pre_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        taps_q <= taps;
                        seed_q <= seed;
                        pre_q  <= pre_len;
                        idx    <= '0;
                        lfsr   <= seed;
                        err_q  <= 1'b0;
                        state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // An all-zero seed or tap mask locks the LFSR; refuse before touching memory.
                    if (seed_q == 8'h00 || taps_q == 8'h00) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= in_msg(idx, pre_q) ? ST_RD : ST_PAD;
                    end
                end
                ST_PAD, ST_WR: begin
                    idx   <= idx_nxt;
                    lfsr  <= lfsr_nxt;
                    state <= after_wr;
                end
                ST_RD: begin
                    state <= ST_WR;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address and data are only driven in the strobe cycle and are zero elsewhere.
    always_comb begin
        mem_addr  = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        case (state)
            ST_PAD: begin
                mem_wr_en = 1'b1;
                mem_addr  = 8'(DST_BASE) + {1'b0, idx};
                mem_wdata = SPACE ^ lfsr;
            end
            ST_RD: begin
                mem_rd_en = 1'b1;
                mem_addr  = 8'(SRC_BASE) + {1'b0, idx} - {2'b00, pre_q};
            end
            ST_WR: begin
                mem_wr_en = 1'b1;
                mem_addr  = 8'(DST_BASE) + {1'b0, idx};
                mem_wdata = mem_rdata ^ lfsr;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state == ST_CHECK) || (state == ST_PAD) ||
                  (state == ST_RD)    || (state == ST_WR);
    assign done = (state == ST_DONE);
    assign err  = err_q;

endmodule
